tuple_collector: RTL
====================

# tuple_collector

Downstream stage for the zero-sum triplet finder. Accepts each triplet the finder presents with its four-phase valid/ack handshake, buffers it in a first-word-fall-through FIFO, and presents the buffered triplets on a ready/valid stream to the consumer (result printer or host interface). When the FIFO is full, it withholds ack so the finder stalls without losing results.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  triplet present from finder; level, held until ack seen
- in_t1, in_t2, in_t3  in  8 each  triplet elements, two's complement, stable while in_valid=1
- in_ack  out  1  four-phase acknowledge to finder
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head on clk edge when out_valid=1
- out_t1, out_t2, out_t3  out  8 each  head triplet
- level  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  level==DEPTH
- total  out  8  triplets stored since reset, saturates at 255
- sum_err  out  1  sticky sum-check failure (see Configuration)

## Operation
- Input FSM has three states:
  - IDLE: in_ack=0.
    - in_valid=1 and !full at edge: capture triplet, go to ACK.
    - in_valid=1 and full: go to STALL.
  - STALL: in_ack=0. Move to ACK and capture the triplet on the first edge where !full.
  - ACK: in_ack=1. When in_valid=0 at edge, go to IDLE and drop in_ack.
- One capture per handshake. in_valid staying high in ACK never causes a second write.
- The full test uses the registered full. A pop on the same edge does not free space for a write on that edge.
- Simultaneous push and pop (not full, not empty): level unchanged and both take effect.
- Pop when empty is ignored. out_valid=0 implies the out_t* values are don't-care but held.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- total increments on every stored triplet and holds at 255.
- Reset mid-handshake:
  - FSM goes to IDLE, in_ack=0, FIFO is emptied, and total and sum_err clear.
  - A finder still holding in_valid=1 after reset release is treated as a new triplet.

## Timing
- Reset values: in_ack=0, out_valid=0, out_t*=0, level=0, full=0, total=0, sum_err=0. All outputs are registered.
- Capture at edge N means:
  - in_ack=1 after edge N.
  - If the FIFO was empty, out_valid=1 and out_t* = the triplet after edge N (one-cycle latency).
  - level and total update after edge N.
- in_valid falls, sampled at edge M: in_ack=0 after edge M.
- Minimum handshake is 2 cycles per triplet when not full.
- Pop at edge P: next entry (or out_valid=0) is visible after edge P, and level updates after edge P.

## Configuration
- SUM_CHECK_EN defined:
  - Each captured triplet is summed as 10-bit sign-extended values.
  - A nonzero sum sets sum_err (sticky until reset). The triplet is still acked but not written; level and total do not change.
  - The FIFO full check still applies before ack.
- SUM_CHECK_EN undefined: no adder, sum_err is tied 0, and every triplet is stored.

## Test plan
- Reset, then finder presents (-3,1,2) with a four-phase handshake -> in_ack high one cycle after capture; out_valid=1, out_t*=(-3,1,2), level=1, total=1.
- DEPTH=8, out_ready=0, push 9 triplets:
  - The 9th gets no ack and the FSM stays in STALL with full=1.
  - Then pop once -> ack for the 9th follows, and level returns to 8.
- Hold in_valid high for 10 cycles after ack -> exactly one entry is written and in_ack stays 1 until in_valid=0.
- level=3 with out_ready=1 and a capture on the same edge -> level stays 3 and FIFO order is preserved across pointer wrap over 20 triplets.
- Assert reset while in ACK with level=5 -> all outputs at reset values immediately; in_valid still high after release -> captured as a new entry, total=1.
- With SUM_CHECK_EN, present (1,1,1) -> acked, sum_err=1, level and total unchanged. A following (-4,2,2) stores normally and sum_err stays 1.

Source files
------------

// File: rtl/tuple_collector.sv
// tuple_collector: takes triplets from the zero-sum finder over a four-phase
// valid/ack handshake, queues them in a first-word-fall-through FIFO and
// presents the head on a ready/valid stream. Ack is withheld while the FIFO
// is full, so the finder stalls without losing results.
// Optional build macro SUM_CHECK_EN: triplets whose 10-bit sign-extended sum
// is nonzero are acked but dropped, and the sticky sum_err flag is raised.
module tuple_collector #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_t1,
    input  logic [7:0]               in_t2,
    input  logic [7:0]               in_t3,
    output logic                     in_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_t1,
    output logic [7:0]               out_t2,
    output logic [7:0]               out_t3,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [7:0]               total,
    output logic                     sum_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

    state_t          state, state_nxt;
    logic            capture;
    logic            push, pop, sum_ok;
    logic [23:0]     in_data, head_nxt;
    logic [23:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     level_nxt;

    assign in_data = {in_t1, in_t2, in_t3};

`ifdef SUM_CHECK_EN
    function automatic logic signed [9:0] sext10(input logic [7:0] v);
        return {{2{v[7]}}, v};
    endfunction

    logic signed [9:0] sum;
    assign sum    = sext10(in_t1) + sext10(in_t2) + sext10(in_t3);
    assign sum_ok = (sum == 10'sd0);
`else
    assign sum_ok = 1'b1;
`endif

    // a bad-sum triplet still completes its handshake but is never written
    assign push = capture && sum_ok;
    assign pop  = out_valid && out_ready;

    // handshake FSM: decide next state and whether this edge captures;
    // the full test uses the registered flag, so a same-edge pop never frees space
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!full) begin
                        state_nxt = ACK;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                if (!full) begin
                    state_nxt = ACK;
                    capture   = 1'b1;
                end
            end
            ACK: begin
                if (!in_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // next occupancy and next head word of the fall-through output register
    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + (AW+1)'(1);
        else if (!push && pop) level_nxt = level - (AW+1)'(1);

        head_nxt = {out_t1, out_t2, out_t3};
        if (push && (level == '0 || (level == (AW+1)'(1) && pop)))
            head_nxt = in_data;
        else if (pop && level > (AW+1)'(1))
            head_nxt = mem[rd_ptr + AW'(1)];
    end

    // control state: FSM, ack, pointers, occupancy flags and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ack    <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            total     <= '0;
        end else begin
            state     <= state_nxt;
            in_ack    <= (state_nxt == ACK);
            level     <= level_nxt;
            full      <= (level_nxt == DEPTH_L);
            out_valid <= (level_nxt != '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && total != 8'hFF) total <= total + 8'd1;
        end
    end

`ifdef SUM_CHECK_EN
    // sticky flag for any acked triplet whose sum was nonzero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  sum_err <= 1'b0;
        else if (capture && !sum_ok) sum_err <= 1'b1;
    end
`else
    assign sum_err = 1'b0;
`endif

    // FIFO storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // registered head word; held when the FIFO drains
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {out_t1, out_t2, out_t3} <= '0;
        else        {out_t1, out_t2, out_t3} <= head_nxt;
    end

endmodule
